seq_lock_fsm: RTL and testbench
===============================

// Module: seq_lock_fsm
// PURPOSE
//  Parametrised switch-sequence lock controller for the lab board. It detects presses on NUM_SW
//  switches and compares a CODE_LEN-long sequence against a loadable code register.
//  Results are reported only after a full entry, so no early reveal of the failing digit.
//  Adds entry timeout, fail counting with timed lockout, timed unlock and a 2-bit status code Z.
// PARAMETERS
//  NUM_SW       4      number of switch inputs (>=2); IDXW = $clog2(NUM_SW)
//  CODE_LEN     4      presses per code (>=1)
//  DEFAULT_CODE 8'hE4  reset code, CODE_LEN*IDXW bits, digit k at [k*IDXW +: IDXW] (default 0,1,2,3)
//  TIMEOUT      16     idle cycles allowed between presses in ENTRY
//  OPEN_CYC     8      cycles unlock stays high
//  MAX_FAIL     3      consecutive failures that trigger lockout (>=1)
//  LOCKOUT_CYC  32     lockout duration in cycles
// PORTS
//  clk       in   1                       clock, rising edge
//  reset     in   1                       asynchronous, active-high
//  sw        in   NUM_SW                  switch levels, already synchronised
//  code_in   in   CODE_LEN*IDXW           new code, same packing as DEFAULT_CODE
//  code_load in   1                       load code_in (1-cycle pulse)
//  relock    in   1                       force OPEN -> IDLE
//  state     out  3                       0 IDLE, 1 ENTRY, 2 OPEN, 3 LOCKOUT
//  z         out  2                       status: IDLE 01, ENTRY 10, OPEN 11, LOCKOUT 00
//  unlock    out  1                       high iff state==OPEN
//  alarm     out  1                       high iff state==LOCKOUT
//  pos       out  $clog2(CODE_LEN+1)      presses taken in the current entry
//  fail_cnt  out  $clog2(MAX_FAIL+1)      consecutive failures
// BEHAVIOUR
//  Reset: state=0, z=01, unlock=0, alarm=0, pos=0, fail_cnt=0, timer=0, err=0, code=DEFAULT_CODE,
//   sw_q=0. Reset is honoured at any time, including mid-entry, OPEN or LOCKOUT.
//  sw_q registers sw every cycle.
//  press: sw==0 -> one-hot transition (sw_q==0 && sw!=0), evaluated at the sampling edge.
//   digit is the index of the set bit. Multi-hot (>1 bit set) counts as a press with mismatch.
//   A held switch makes no further presses; all switches must return to 0 before the next press.
//  Latency: state/pos update on the same edge at which sw is first sampled non-zero.
//  Mismatch: digit != code[pos], or the press is multi-hot.
//  Timer: single counter; cleared on every state change and on every press in ENTRY;
//   otherwise +1 per cycle. Width sized for max(TIMEOUT, OPEN_CYC, LOCKOUT_CYC).
//  IDLE: a press moves to ENTRY with pos=1 and err=mismatch.
//   If CODE_LEN==1, the press is resolved immediately (see resolve).
//  ENTRY: each press does pos+1 and err|=mismatch; the press that makes pos==CODE_LEN resolves.
//  resolve:
//   - err==0 -> OPEN, fail_cnt=0.
//   - err==1 -> fail_cnt+1; LOCKOUT if that equals MAX_FAIL, else IDLE. pos=0, err=0.
//  ENTRY timeout: with no press and timer==TIMEOUT-1 -> failure resolve (as err==1).
//   Exactly TIMEOUT idle cycles after the last press. A press in the same cycle wins.
//  OPEN: presses ignored; timer==OPEN_CYC-1 or relock -> IDLE. unlock is high exactly OPEN_CYC cycles.
//  LOCKOUT: presses and relock ignored; timer==LOCKOUT_CYC-1 -> IDLE with fail_cnt=0.
//  code_load: accepted only in IDLE or OPEN, ignored elsewhere. New code takes effect next cycle.
//   A press in the same cycle compares against the old code.
//  z, unlock and alarm are decoded from the state register only (Moore outputs).
//  Undefined state encodings (4-7) -> IDLE.
// TESTING (defaults)
//  1 Press sw=0001,0000,0010,0000,0100,0000,1000 -> state 1 after the 1st press; state=2, z=11,
//    unlock=1 for exactly 8 cycles after the 4th press; then state=0, fail_cnt=0.
//  2 Press digits 0,1,3,3 -> state stays 1 through the 3rd press; after the 4th: state=0, fail_cnt=1.
//  3 Three bad entries -> state=3, alarm=1, z=00; presses during LOCKOUT leave pos=0;
//    after 32 cycles state=0, fail_cnt=0.
//  4 Press digit 0, then sw=0 for 16 cycles -> state=0, pos=0, fail_cnt=1.
//    A repeat with the 2nd press at cycle 15 keeps ENTRY.
//  5 sw=0011 counts as a mismatched press; holding 0001 for 5 cycles gives pos=1 only.
//    code_load 8'h1B in IDLE, then digits 3,2,1,0 -> OPEN.
//  6 reset pulse mid-ENTRY (pos=2) -> all outputs at reset values; the default code opens again.

Source files
------------

// File: rtl/seq_lock_fsm_if.sv
// Bus between the lock controller and its user: switch/code inputs and status outputs.
interface seq_lock_fsm_if #(
  parameter int NUM_SW   = 4,
  parameter int CODE_LEN = 4,
  parameter int MAX_FAIL = 3
);
  localparam int IDXW = $clog2(NUM_SW);
  localparam int POSW = $clog2(CODE_LEN + 1);
  localparam int FCW  = $clog2(MAX_FAIL + 1);

  logic [NUM_SW-1:0]        sw;
  logic [CODE_LEN*IDXW-1:0] code_in;
  logic                     code_load;
  logic                     relock;
  logic [2:0]               state;
  logic [1:0]               z;
  logic                     unlock;
  logic                     alarm;
  logic [POSW-1:0]          pos;
  logic [FCW-1:0]           fail_cnt;

  modport master (
    output sw, code_in, code_load, relock,
    input  state, z, unlock, alarm, pos, fail_cnt
  );

  modport slave (
    input  sw, code_in, code_load, relock,
    output state, z, unlock, alarm, pos, fail_cnt
  );
endinterface

// File: rtl/seq_lock_fsm.sv
// Switch-sequence lock: collects CODE_LEN presses, reports pass/fail only after the
// full entry, with entry timeout, consecutive-fail lockout and timed unlock.
module seq_lock_fsm #(
  parameter int NUM_SW      = 4,
  parameter int CODE_LEN    = 4,
  parameter logic [CODE_LEN*$clog2(NUM_SW)-1:0] DEFAULT_CODE = 8'hE4,
  parameter int TIMEOUT     = 16,
  parameter int OPEN_CYC    = 8,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 32
) (
  input logic          clk,
  input logic          reset,
  seq_lock_fsm_if.slave bus
);
  localparam int IDXW  = $clog2(NUM_SW);
  localparam int CODEW = CODE_LEN * IDXW;
  localparam int POSW  = $clog2(CODE_LEN + 1);
  localparam int FCW   = $clog2(MAX_FAIL + 1);
  localparam int TMAX0 = (TIMEOUT > OPEN_CYC) ? TIMEOUT : OPEN_CYC;
  localparam int TMAX  = (TMAX0 > LOCKOUT_CYC) ? TMAX0 : LOCKOUT_CYC;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int NDIG  = 2 ** POSW;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_OPEN    = 3'd2,
    S_LOCKOUT = 3'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [POSW-1:0]   pos_reg, pos_next, pos_inc;
  logic [FCW-1:0]    fail_reg, fail_next, fail_inc;
  logic [TW-1:0]     timer_reg;
  logic              timer_clear;
  logic              err_reg, err_next;
  logic [CODEW-1:0]  code_reg, code_next;
  logic [NUM_SW-1:0] sw_q;

  logic              press, multi, mismatch;
  logic              do_resolve, res_err;
  logic [IDXW-1:0]   digit;
  logic [IDXW-1:0]   digit_acc [NUM_SW+1];
  logic [IDXW-1:0]   code_digit [NDIG];

  // Encode the pressed switch index by OR-ing the indices of all set bits; only
  // meaningful for one-hot input, multi-hot is flagged separately as a mismatch.
  assign digit_acc[0] = '0;
  for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_enc
    assign digit_acc[gi+1] = digit_acc[gi] | (bus.sw[gi] ? IDXW'(gi) : '0);
  end
  assign digit = digit_acc[NUM_SW];

  // Unpack the code register into digits; the table is padded to a power of two so
  // it can be indexed by pos directly.
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
    if (gi < CODE_LEN) begin : g_real
      assign code_digit[gi] = code_reg[gi*IDXW +: IDXW];
    end else begin : g_pad
      assign code_digit[gi] = '0;
    end
  end

  assign press    = (sw_q == '0) && (bus.sw != '0);
  assign multi    = (bus.sw & (bus.sw - NUM_SW'(1))) != '0;
  assign mismatch = multi || (digit != code_digit[pos_reg]);
  assign pos_inc  = pos_reg + POSW'(1);
  assign fail_inc = fail_reg + FCW'(1);

  // State and datapath registers, asynchronously reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      pos_reg   <= '0;
      fail_reg  <= '0;
      timer_reg <= '0;
      err_reg   <= 1'b0;
      code_reg  <= DEFAULT_CODE;
      sw_q      <= '0;
    end else begin
      state_reg <= state_next;
      pos_reg   <= pos_next;
      fail_reg  <= fail_next;
      timer_reg <= timer_clear ? '0 : timer_reg + TW'(1);
      err_reg   <= err_next;
      code_reg  <= code_next;
      sw_q      <= bus.sw;
    end
  end

  // Next-state logic: collect presses, resolve full/timed-out entries, time OPEN/LOCKOUT.
  always_comb begin
    state_next = state_reg;
    pos_next   = pos_reg;
    err_next   = err_reg;
    fail_next  = fail_reg;
    code_next  = code_reg;
    do_resolve = 1'b0;
    res_err    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (press) begin
          if (CODE_LEN == 1) begin
            do_resolve = 1'b1;
            res_err    = mismatch;
          end else begin
            state_next = S_ENTRY;
            pos_next   = POSW'(1);
            err_next   = mismatch;
          end
        end
      end
      S_ENTRY: begin
        if (press) begin
          if (pos_inc == POSW'(CODE_LEN)) begin
            do_resolve = 1'b1;
            res_err    = err_reg | mismatch;
          end else begin
            pos_next = pos_inc;
            err_next = err_reg | mismatch;
          end
        end else if (timer_reg == TW'(TIMEOUT - 1)) begin
          do_resolve = 1'b1;
          res_err    = 1'b1;
        end
      end
      S_OPEN: begin
        if (bus.relock || (timer_reg == TW'(OPEN_CYC - 1))) begin
          state_next = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (timer_reg == TW'(LOCKOUT_CYC - 1)) begin
          state_next = S_IDLE;
          fail_next  = '0;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // A finished entry always starts the next one from scratch.
    if (do_resolve) begin
      pos_next = '0;
      err_next = 1'b0;
      if (!res_err) begin
        state_next = S_OPEN;
        fail_next  = '0;
      end else begin
        fail_next  = fail_inc;
        state_next = (fail_inc == FCW'(MAX_FAIL)) ? S_LOCKOUT : S_IDLE;
      end
    end

    if (bus.code_load && (state_reg == S_IDLE || state_reg == S_OPEN)) begin
      code_next = bus.code_in;
    end

    timer_clear = (state_next != state_reg) || (state_reg == S_ENTRY && press);
  end

  // Moore status decode from the state register.
  always_comb begin
    bus.z      = 2'b01;
    bus.unlock = 1'b0;
    bus.alarm  = 1'b0;
    case (state_reg)
      S_IDLE:    bus.z = 2'b01;
      S_ENTRY:   bus.z = 2'b10;
      S_OPEN:    begin bus.z = 2'b11; bus.unlock = 1'b1; end
      S_LOCKOUT: begin bus.z = 2'b00; bus.alarm  = 1'b1; end
      default:   bus.z = 2'b01;
    endcase
  end

  assign bus.state    = state_reg;
  assign bus.pos      = pos_reg;
  assign bus.fail_cnt = fail_reg;

endmodule

// File: tb/tb_seq_lock_fsm.sv
// Bench for seq_lock_fsm: directed scenarios with randomized timing/content, every
// cycle compared against a queue-based behavioural model of the lock.
module tb_seq_lock_fsm;
  localparam int NSW = 4;
  localparam int CLEN = 4;
  localparam int TOUT = 16;
  localparam int OCYC = 8;
  localparam int MAXF = 3;
  localparam int LCYC = 32;
  localparam logic [7:0] DEF = 8'hE4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  string step_name = "reset";

  seq_lock_fsm_if #(.NUM_SW(NSW), .CODE_LEN(CLEN), .MAX_FAIL(MAXF)) bus ();

  seq_lock_fsm dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 entry, 2 open, 3 lockout; a queue of per-press verdicts.
  int   m_mode;
  bit   m_okq[$];
  int   m_fail;
  int   m_cnt;
  int   m_code[CLEN];
  logic [3:0] m_prev;

  task automatic model_reset();
    m_mode = 0;
    m_okq.delete();
    m_fail = 0;
    m_cnt  = 0;
    m_prev = 4'b0;
    for (int k = 0; k < CLEN; k++) m_code[k] = int'((DEF >> (2 * k)) & 8'h3);
  endtask

  task automatic resolve(input bit good);
    m_okq.delete();
    m_cnt = 0;
    if (good) begin
      m_mode = 2;
      m_fail = 0;
    end else begin
      m_fail++;
      m_mode = (m_fail == MAXF) ? 3 : 0;
    end
  endtask

  task automatic model_step(input logic [3:0] s, input logic ld, input logic [7:0] ci,
                            input logic rl);
    bit press, multi, ok, all_ok;
    int d, old_mode;
    press = (m_prev == 4'b0) && (s != 4'b0);
    multi = $countones(s) > 1;
    d = 0;
    for (int i = 0; i < NSW; i++) if (s[i]) d = i;
    old_mode = m_mode;
    case (old_mode)
      0, 1: begin
        if (press) begin
          ok = !multi && (d == m_code[m_okq.size()]);
          m_okq.push_back(ok);
          m_mode = 1;
          m_cnt = 0;
          if (m_okq.size() == CLEN) begin
            all_ok = 1'b1;
            foreach (m_okq[i]) if (!m_okq[i]) all_ok = 1'b0;
            resolve(all_ok);
          end
        end else if (old_mode == 1) begin
          m_cnt++;
          if (m_cnt == TOUT) resolve(1'b0);
        end
      end
      2: begin
        m_cnt++;
        if (rl || m_cnt == OCYC) begin m_mode = 0; m_cnt = 0; end
      end
      default: begin
        m_cnt++;
        if (m_cnt == LCYC) begin m_mode = 0; m_fail = 0; m_cnt = 0; end
      end
    endcase
    if (ld && (old_mode == 0 || old_mode == 2))
      for (int k = 0; k < CLEN; k++) m_code[k] = int'((ci >> (2 * k)) & 8'h3);
    m_prev = s;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s/%s observed=%0h expected=%0h", step_name, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [1:0] zt [4];
    zt[0] = 2'b01; zt[1] = 2'b10; zt[2] = 2'b11; zt[3] = 2'b00;
    chk("state",    8'(bus.state),    8'(m_mode));
    chk("z",        8'(bus.z),        8'(zt[m_mode]));
    chk("unlock",   8'(bus.unlock),   8'(m_mode == 2));
    chk("alarm",    8'(bus.alarm),    8'(m_mode == 3));
    chk("pos",      8'(bus.pos),      8'(m_okq.size()));
    chk("fail_cnt", 8'(bus.fail_cnt), 8'(m_fail));
  endtask

  task automatic tick(input logic [3:0] s, input logic ld, input logic [7:0] ci, input logic rl);
    bus.sw = s; bus.code_load = ld; bus.code_in = ci; bus.relock = rl;
    @(posedge clk);
    model_step(s, ld, ci, rl);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(4'b0, 1'b0, 8'h0, 1'b0);
  endtask

  task automatic press(input int d, input int hold, input int gap);
    for (int i = 0; i < hold; i++) tick(4'(1 << d), 1'b0, 8'h0, 1'b0);
    idle(gap);
  endtask

  task automatic good_entry();
    for (int k = 0; k < CLEN; k++) press(m_code[k], $urandom_range(1, 3), $urandom_range(1, 4));
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    bus.sw = '0; bus.code_in = '0; bus.code_load = 1'b0; bus.relock = 1'b0;
    model_reset();
    #12;
    check_all();
    reset = 1'b0;

    step_name = "good_entry";
    good_entry();
    idle(10);

    step_name = "bad_0133";
    press(0, 1, 1); press(1, 2, 2); press(3, 1, 1); press(3, 1, 3);

    step_name = "lockout";
    for (int e = 0; e < 3; e++) begin
      for (int k = 0; k < CLEN - 1; k++) press($urandom_range(0, 3), 1, 1);
      press((m_code[CLEN-1] + 1) % 4, 1, 1);
    end
    for (int i = 0; i < 4; i++) begin
      press($urandom_range(0, 3), 1, 1);
      tick(4'b0, 1'b0, 8'h0, 1'b1);
    end
    idle(LCYC + 4);

    step_name = "timeout";
    press(m_code[0], 1, TOUT);
    press(m_code[0], 1, TOUT - 2);
    press(m_code[1], 1, 1);
    press(m_code[2], 1, 1);
    press(m_code[3], 1, OCYC + 2);

    step_name = "multihot";
    press(0, 5, 1);
    tick(4'b0011, 1'b0, 8'h0, 1'b0);
    idle(1);
    press(2, 1, 1); press(3, 1, 1);

    step_name = "code_load";
    tick(4'b0, 1'b1, 8'h1B, 1'b0);
    press(3, 1, 1);
    tick(4'b0, 1'b1, 8'hE4, 1'b0);
    press(2, 1, 1); press(1, 1, 1); press(0, 1, 2);
    tick(4'b0, 1'b0, 8'h0, 1'b1);
    idle(2);
    tick(4'b0001, 1'b1, 8'hE4, 1'b0);
    idle(1);
    press(1, 1, 1); press(2, 1, 1); press(3, 1, 1);

    step_name = "reset_mid";
    press(m_code[0], 1, 1); press(m_code[1], 1, 1);
    do_reset();
    good_entry();
    idle(OCYC + 2);

    step_name = "random";
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [3:0] s;
      r = $urandom_range(0, 9);
      if (r < 5) s = 4'b0;
      else if (r < 9) s = 4'(1 << $urandom_range(0, 3));
      else s = 4'($urandom);
      tick(s, $urandom_range(0, 19) == 0, 8'($urandom), $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) begin
        idle(1);
        good_entry();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
